// File: rtl/csa_accumulator.sv
// Carry-save accumulator: one 3:2 compression per accepted term, closed pair held for the KSA.
// Pair valid the cycle after the closing beat; in_ready drops while a pair is held (one bubble per group).
module csa_accumulator #(
   parameter int WIDTH     = 8,
   parameter int MAX_TERMS = 16,
   parameter int ACC_WIDTH = WIDTH + $clog2(MAX_TERMS),
   parameter int CNT_WIDTH = $clog2(MAX_TERMS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_sum,
   output logic [ACC_WIDTH-1:0] out_carry,
   output logic [CNT_WIDTH-1:0] out_count,
   output logic                 out_trunc
);

   typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

   localparam logic [CNT_WIDTH-1:0] CAP = CNT_WIDTH'(MAX_TERMS);

   state_t               state;
   logic [ACC_WIDTH-1:0] d_ext;
   logic [ACC_WIDTH-1:0] sum_nxt;
   logic [ACC_WIDTH-1:0] maj;
   logic [ACC_WIDTH-1:0] carry_nxt;
   logic [CNT_WIDTH-1:0] cnt_nxt;
   logic                 accept;
   logic                 cap_hit;

   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == HOLD);
   assign accept    = in_valid && in_ready;

   assign d_ext     = {{(ACC_WIDTH-WIDTH){1'b0}}, in_data};
   assign sum_nxt   = out_sum ^ out_carry ^ d_ext;
   assign maj       = (out_sum & out_carry) | (out_sum & d_ext) | (out_carry & d_ext);
   // Carry weight is one bit higher; the MSB carry cannot be set for in-range groups.
   assign carry_nxt = {maj[ACC_WIDTH-2:0], 1'b0};
   assign cnt_nxt   = out_count + CNT_WIDTH'(1);
   assign cap_hit   = (cnt_nxt == CAP);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACCUM;
         out_sum   <= '0;
         out_carry <= '0;
         out_count <= '0;
         out_trunc <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  out_sum   <= sum_nxt;
                  out_carry <= carry_nxt;
                  out_count <= cnt_nxt;
                  if (in_last || cap_hit) begin
                     state     <= HOLD;
                     out_trunc <= cap_hit && !in_last;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= ACCUM;
                  out_sum   <= '0;
                  out_carry <= '0;
                  out_count <= '0;
                  out_trunc <= 1'b0;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_csa_accumulator.sv
// Bench for csa_accumulator: arithmetic group model checked every cycle, plus directed literal checks.
module tb_csa_accumulator;

   localparam int WIDTH     = 8;
   localparam int MAX_TERMS = 16;
   localparam int ACC_W     = 12;
   localparam int CNT_W     = 5;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic [ACC_W-1:0] out_carry;
   logic [CNT_W-1:0] out_count;
   logic             out_trunc;
   logic [ACC_W-1:0] ksa_out;

   int total = 0;
   int bad   = 0;

   // Reference state: exact running total of the open or held group.
   int m_sum   = 0;
   int m_cnt   = 0;
   bit m_hold  = 0;
   bit m_trunc = 0;

   bit chk_en     = 0;
   bit ready_rand = 0;
   int dut_hs     = 0;
   int exp_groups = 0;

   csa_accumulator #(
      .WIDTH(WIDTH),
      .MAX_TERMS(MAX_TERMS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_last(in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum(out_sum),
      .out_carry(out_carry),
      .out_count(out_count),
      .out_trunc(out_trunc)
   );

   // Final adder stage with c_in = 0, modulo the accumulator width.
   assign ksa_out = out_sum + out_carry;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_sum = 0; m_cnt = 0; m_hold = 0; m_trunc = 0;
      end else if (!m_hold) begin
         if (in_valid) begin
            m_sum = m_sum + int'(in_data);
            m_cnt = m_cnt + 1;
            if (in_last || m_cnt == MAX_TERMS) begin
               m_hold  = 1;
               m_trunc = !in_last;
            end
         end
      end else if (out_ready) begin
         dut_hs++;
         m_sum = 0; m_cnt = 0; m_hold = 0; m_trunc = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready",  64'(in_ready),  64'(!m_hold));
         chk("out_valid", 64'(out_valid), 64'(m_hold));
         chk("ksa_sum",   64'(ksa_out),   64'(m_sum));
         chk("count",     64'(out_count), 64'(m_cnt));
         chk("trunc",     64'(out_trunc), 64'(m_trunc));
      end
   end

   always @(negedge clk) begin
      if (ready_rand) out_ready = ($urandom_range(0, 2) != 0);
   end

   // Called at a negedge; returns at the negedge after the beat is accepted.
   task automatic send(input logic [WIDTH-1:0] d, input logic last);
      int budget = 300;
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      while (!in_ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got in_ready=0 expected 1 within 300 cycles");
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      int len;
      int budget;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_sum",       64'(out_sum),   64'd0);
      chk("rst_carry",     64'(out_carry), 64'd0);
      chk("rst_count",     64'(out_count), 64'd0);
      chk("rst_trunc",     64'(out_trunc), 64'd0);
      chk_en = 1;

      // Two-term group: 0xAA + 36 = 206.
      out_ready = 1'b1;
      send(8'hAA, 1'b0);
      send(8'd36, 1'b1);
      chk("two_valid", 64'(out_valid), 64'd1);
      chk("two_sum",   64'(ksa_out),   64'd206);
      chk("two_count", 64'(out_count), 64'd2);
      chk("two_trunc", 64'(out_trunc), 64'd0);
      exp_groups++;
      @(negedge clk);

      // Cap: sixteen 0xFF terms without in_last.
      out_ready = 1'b0;
      for (int i = 0; i < MAX_TERMS; i++) send(8'hFF, 1'b0);
      chk("cap_valid", 64'(out_valid), 64'd1);
      chk("cap_sum",   64'(ksa_out),   64'd4080);
      chk("cap_count", 64'(out_count), 64'd16);
      chk("cap_trunc", 64'(out_trunc), 64'd1);
      exp_groups++;
      in_valid = 1'b1;
      in_data  = 8'h5A;
      in_last  = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("cap_17th_blocked", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      send(8'h5A, 1'b1);
      chk("single_sum",   64'(out_sum),   64'h5A);
      chk("single_carry", 64'(out_carry), 64'd0);
      chk("single_count", 64'(out_count), 64'd1);
      exp_groups++;
      @(negedge clk);

      // Backpressure: {4,2} held while 9 is offered.
      out_ready = 1'b0;
      send(8'd4, 1'b0);
      send(8'd2, 1'b1);
      in_valid = 1'b1;
      in_data  = 8'd9;
      repeat (5) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_sum",      64'(ksa_out),  64'd6);
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_rel_valid", 64'(out_valid), 64'd0);
      chk("bp_rel_ready", 64'(in_ready),  64'd1);
      chk("bp_rel_sum",   64'(out_sum),   64'd0);
      chk("bp_rel_carry", 64'(out_carry), 64'd0);
      chk("bp_rel_count", 64'(out_count), 64'd0);
      exp_groups++;

      // Reset mid-group discards 3,5,7.
      send(8'd3, 1'b0);
      send(8'd5, 1'b0);
      send(8'd7, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_count", 64'(out_count), 64'd0);
      send(8'd4, 1'b0);
      send(8'd2, 1'b1);
      chk("mid_sum",   64'(ksa_out),   64'd6);
      chk("mid_count", 64'(out_count), 64'd2);
      chk("mid_trunc", 64'(out_trunc), 64'd0);
      exp_groups++;
      @(negedge clk);

      // Random groups with bubbles and stalls.
      ready_rand = 1;
      for (int g = 0; g < 50; g++) begin
         len = $urandom_range(1, MAX_TERMS);
         for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 2)) begin
               in_data = WIDTH'($urandom);
               in_last = 1'($urandom);
               @(negedge clk);
            end
            if (i == len - 1)
               send(WIDTH'($urandom), (len == MAX_TERMS) ? 1'($urandom) : 1'b1);
            else
               send(WIDTH'($urandom), 1'b0);
         end
         exp_groups++;
      end
      ready_rand = 0;
      @(negedge clk);
      out_ready = 1'b1;
      budget = 50;
      while (out_valid && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk("drain_done", 64'(out_valid), 64'd0);
      repeat (2) @(negedge clk);
      chk("group_count", 64'(dut_hs), 64'(exp_groups));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
